// File: rtl/decode_hazard_stage_pkg.sv
// Shared defaults and source-use flag positions for the decode/hazard stage.
package decode_hazard_stage_pkg;
  localparam int DEF_REGI_BITS = 4;
  localparam int DEF_VECT_BITS = 2;
  localparam int DEF_REGI_SIZE = 16;
  localparam int DEF_ELEM_SIZE = 8;
  localparam int DEF_VECT_SIZE = 8;
  localparam int DEF_CTRL_W    = 24;
  localparam int IMM_W         = 8;

  // Bit positions inside use_i = {vsrc2, vsrc1, src2, src1}
  localparam int USE_SRC1  = 0;
  localparam int USE_SRC2  = 1;
  localparam int USE_VSRC1 = 2;
  localparam int USE_VSRC2 = 3;
endpackage

// File: rtl/decode_hazard_stage_scoreboard.sv
// One busy bit per architectural register; flags RAW hazards with same-cycle writeback bypass.
module hazard_scoreboard #(
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [IDX_BITS-1:0] set_idx,
  input  logic                wb_en,
  input  logic [IDX_BITS-1:0] wb_idx,
  input  logic                kill_en,
  input  logic [IDX_BITS-1:0] kill_idx,
  input  logic                rd1_use,
  input  logic [IDX_BITS-1:0] rd1_idx,
  input  logic                rd2_use,
  input  logic [IDX_BITS-1:0] rd2_idx,
  output logic                hazard
);
  localparam int NREG = 1 << IDX_BITS;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en)  set_mask[set_idx]  = 1'b1;
    if (wb_en)   clr_mask[wb_idx]   = 1'b1;
    if (kill_en) clr_mask[kill_idx] = 1'b1;
  end

  // Set is OR-ed in after the clear so a same-cycle issue keeps the register busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= (busy & ~clr_mask) | set_mask;
  end

  assign hazard = (rd1_use && busy[rd1_idx] && !(wb_en && (wb_idx == rd1_idx))) ||
                  (rd2_use && busy[rd2_idx] && !(wb_en && (wb_idx == rd2_idx)));
endmodule

// File: rtl/decode_hazard_stage.sv
// Decode/issue stage: scoreboard-based RAW stalling, writeback operand bypass and one output register.
module decode_hazard_stage
  import decode_hazard_stage_pkg::*;
#(
  parameter int REGI_BITS = DEF_REGI_BITS,
  parameter int VECT_BITS = DEF_VECT_BITS,
  parameter int REGI_SIZE = DEF_REGI_SIZE,
  parameter int ELEM_SIZE = DEF_ELEM_SIZE,
  parameter int VECT_SIZE = DEF_VECT_SIZE,
  parameter int CTRL_W    = DEF_CTRL_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [REGI_BITS-1:0]           src1_i,
  input  logic [REGI_BITS-1:0]           src2_i,
  input  logic [VECT_BITS-1:0]           vsrc1_i,
  input  logic [VECT_BITS-1:0]           vsrc2_i,
  input  logic [3:0]                     use_i,
  input  logic [REGI_BITS-1:0]           int_dest_i,
  input  logic [VECT_BITS-1:0]           vec_dest_i,
  input  logic                           wr_int_i,
  input  logic                           wr_vec_i,
  input  logic [IMM_W-1:0]               imm_i,
  input  logic [CTRL_W-1:0]              ctrl_i,
  input  logic [REGI_SIZE-1:0]           rf_rd1_i,
  input  logic [REGI_SIZE-1:0]           rf_rd2_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] vrf_rd1_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] vrf_rd2_i,
  input  logic                           wb_int_we_i,
  input  logic                           wb_vec_we_i,
  input  logic [REGI_BITS-1:0]           wb_int_dest_i,
  input  logic [VECT_BITS-1:0]           wb_vec_dest_i,
  input  logic [REGI_SIZE-1:0]           wb_int_wd_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] wb_vec_wd_i,
  input  logic                           flush_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [REGI_SIZE-1:0]           int_oper1_o,
  output logic [REGI_SIZE-1:0]           int_oper2_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] vec_oper1_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] vec_oper2_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] vec_imm_o,
  output logic [IMM_W-1:0]               imm_o,
  output logic [REGI_BITS-1:0]           int_dest_o,
  output logic [VECT_BITS-1:0]           vec_dest_o,
  output logic                           wr_int_o,
  output logic                           wr_vec_o,
  output logic [CTRL_W-1:0]              ctrl_o,
  output logic [15:0]                    stall_cnt_o
);
  localparam int VW = ELEM_SIZE * VECT_SIZE;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  function automatic logic [VW-1:0] splat_imm(input logic [IMM_W-1:0] imm);
    logic [VW-1:0] lanes;
    lanes = '0;
    for (int i = 0; i < VECT_SIZE; i++) lanes[i*ELEM_SIZE +: ELEM_SIZE] = ELEM_SIZE'(imm);
    return lanes;
  endfunction

  logic                 haz_int, haz_vec, hazard, issue, kill;
  logic                 vld_p1;
  logic [REGI_SIZE-1:0] int_oper1_p1, int_oper2_p1;
  logic [VW-1:0]        vec_oper1_p1, vec_oper2_p1, vec_imm_p1;
  logic [IMM_W-1:0]     imm_p1;
  logic [REGI_BITS-1:0] int_dest_p1;
  logic [VECT_BITS-1:0] vec_dest_p1;
  logic                 wr_int_p1, wr_vec_p1;
  logic [CTRL_W-1:0]    ctrl_p1;
  logic [15:0]          stall_cnt;

  assign hazard     = haz_int || haz_vec;
  assign in_ready_o = !hazard && !flush_i && (!vld_p1 || out_ready_i);
  assign issue      = in_valid_i && in_ready_o;
  assign kill       = flush_i && vld_p1;

  hazard_scoreboard #(.IDX_BITS(REGI_BITS)) u_int_sb (
    .clk(clk), .rst(rst),
    .set_en(issue && wr_int_i), .set_idx(int_dest_i),
    .wb_en(wb_int_we_i), .wb_idx(wb_int_dest_i),
    .kill_en(kill && wr_int_p1), .kill_idx(int_dest_p1),
    .rd1_use(use_i[USE_SRC1]), .rd1_idx(src1_i),
    .rd2_use(use_i[USE_SRC2]), .rd2_idx(src2_i),
    .hazard(haz_int)
  );

  hazard_scoreboard #(.IDX_BITS(VECT_BITS)) u_vec_sb (
    .clk(clk), .rst(rst),
    .set_en(issue && wr_vec_i), .set_idx(vec_dest_i),
    .wb_en(wb_vec_we_i), .wb_idx(wb_vec_dest_i),
    .kill_en(kill && wr_vec_p1), .kill_idx(vec_dest_p1),
    .rd1_use(use_i[USE_VSRC1]), .rd1_idx(vsrc1_i),
    .rd2_use(use_i[USE_VSRC2]), .rd2_idx(vsrc2_i),
    .hazard(haz_vec)
  );

  // Stage p0 -> p1: operand bypass from writeback and output register load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1       <= 1'b0;
      int_oper1_p1 <= '0;
      int_oper2_p1 <= '0;
      vec_oper1_p1 <= '0;
      vec_oper2_p1 <= '0;
      vec_imm_p1   <= '0;
      imm_p1       <= '0;
      int_dest_p1  <= '0;
      vec_dest_p1  <= '0;
      wr_int_p1    <= 1'b0;
      wr_vec_p1    <= 1'b0;
      ctrl_p1      <= '0;
    end else begin
      if (issue) begin
        vld_p1       <= 1'b1;
        int_oper1_p1 <= (wb_int_we_i && wb_int_dest_i == src1_i) ? wb_int_wd_i : rf_rd1_i;
        int_oper2_p1 <= (wb_int_we_i && wb_int_dest_i == src2_i) ? wb_int_wd_i : rf_rd2_i;
        vec_oper1_p1 <= (wb_vec_we_i && wb_vec_dest_i == vsrc1_i) ? wb_vec_wd_i : vrf_rd1_i;
        vec_oper2_p1 <= (wb_vec_we_i && wb_vec_dest_i == vsrc2_i) ? wb_vec_wd_i : vrf_rd2_i;
        vec_imm_p1   <= splat_imm(imm_i);
        imm_p1       <= imm_i;
        int_dest_p1  <= int_dest_i;
        vec_dest_p1  <= vec_dest_i;
        wr_int_p1    <= wr_int_i;
        wr_vec_p1    <= wr_vec_i;
        ctrl_p1      <= ctrl_i;
      end else if (flush_i || out_ready_i) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      stall_cnt <= '0;
    else if (in_valid_i && hazard) stall_cnt <= sat_inc(stall_cnt);
  end

  assign out_valid_o = vld_p1;
  assign int_oper1_o = int_oper1_p1;
  assign int_oper2_o = int_oper2_p1;
  assign vec_oper1_o = vec_oper1_p1;
  assign vec_oper2_o = vec_oper2_p1;
  assign vec_imm_o   = vec_imm_p1;
  assign imm_o       = imm_p1;
  assign int_dest_o  = int_dest_p1;
  assign vec_dest_o  = vec_dest_p1;
  assign wr_int_o    = wr_int_p1;
  assign wr_vec_o    = wr_vec_p1;
  assign ctrl_o      = ctrl_p1;
  assign stall_cnt_o = stall_cnt;
endmodule

// File: doc/decode_hazard_stage.md
DECODE_HAZARD_STAGE -- requirements
Module: decode_hazard_stage

Interface
REQ-001 Parameters SHALL be REGI_BITS 4 (int reg index width), VECT_BITS 2 (vec reg index width), REGI_SIZE 16 (int data width), ELEM_SIZE 8 (lane width), VECT_SIZE 8 (lane count), CTRL_W 24 (opaque control bundle width).
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  decoded instruction present.
- in_ready_o  out  1  stage accepts instruction this cycle.
- src1_i, src2_i  in  REGI_BITS  int source indices.
- vsrc1_i, vsrc2_i  in  VECT_BITS  vec source indices.
- use_i  in  4  source used flags {vsrc2,vsrc1,src2,src1}.
- int_dest_i  in  REGI_BITS; vec_dest_i  in  VECT_BITS  destinations.
- wr_int_i, wr_vec_i  in  1  instruction writes int / vec dest.
- imm_i  in  8  immediate; ctrl_i  in  CTRL_W  control bundle.
- rf_rd1_i, rf_rd2_i  in  REGI_SIZE; vrf_rd1_i, vrf_rd2_i  in  ELEM_SIZE*VECT_SIZE  register-file read data, combinational from src indices.
- wb_int_we_i, wb_vec_we_i  in  1; wb_int_dest_i  in  REGI_BITS; wb_vec_dest_i  in  VECT_BITS; wb_int_wd_i  in  REGI_SIZE; wb_vec_wd_i  in  ELEM_SIZE*VECT_SIZE  writeback.
- flush_i  in  1  discard instruction held in output register.
- out_valid_o  out  1; out_ready_i  in  1  downstream handshake.
- int_oper1_o, int_oper2_o  out  REGI_SIZE; vec_oper1_o, vec_oper2_o, vec_imm_o  out  ELEM_SIZE*VECT_SIZE; imm_o  out  8; int_dest_o  out  REGI_BITS; vec_dest_o  out  VECT_BITS; wr_int_o, wr_vec_o  out  1; ctrl_o  out  CTRL_W.
- stall_cnt_o  out  16  hazard-stall cycle counter.

Function
REQ-003 Scoreboard SHALL hold one busy bit per int register (2**REGI_BITS) and per vec register (2**VECT_BITS).
REQ-004 Hazard SHALL be: any used source whose busy bit is set, unless the same-cycle writeback targets that register (bypass).
REQ-005 in_ready_o SHALL be !hazard && !flush_i && (!out_valid_o || out_ready_i).
REQ-006 Issue (in_valid_i && in_ready_o) SHALL load the output register next edge and set out_valid_o; latency exactly 1 cycle.
REQ-007 On issue, busy bit of int_dest_i SHALL set when wr_int_i, vec_dest_i when wr_vec_i.
REQ-008 Writeback SHALL clear busy bit of its destination; same-cycle set and clear of one register: set wins.
REQ-009 Operands SHALL select writeback data when wb_*_we_i and wb dest equals source index, else register-file data.
REQ-010 vec_imm_o SHALL be imm_i zero-extended to ELEM_SIZE, replicated across VECT_SIZE lanes.
REQ-011 out_valid_o && !out_ready_i && !flush_i SHALL hold all outputs stable.
REQ-012 out_valid_o && out_ready_i without new issue SHALL clear out_valid_o next edge.
REQ-013 flush_i SHALL clear out_valid_o next edge and clear busy bits set by the held instruction (if valid); flush dominates out_ready_i and blocks issue that cycle.
REQ-014 stall_cnt_o SHALL increment each cycle with in_valid_i && hazard, saturating at 16'hFFFF.
REQ-015 Data outputs SHALL be don't-care-safe: updated only on issue.

Reset
REQ-016 rst low SHALL asynchronously clear out_valid_o, all busy bits, stall_cnt_o and all data/control outputs to 0.
REQ-017 Reset mid-stall SHALL discard held and pending instructions; in_ready_o SHALL be 1 in the first cycle after release.

Structure
REQ-018 Default parameters and the use_i bit-position constants SHALL live in the shared core package.
REQ-019 Scoreboard SHALL be a sub-module hazard_scoreboard, parametrised by index width, instantiated once for int and once for vec.

Verification
REQ-020 Back-to-back independent: src r1,r2 idle, out_ready_i=1 -> issue every cycle, out_valid_o one cycle later.
REQ-021 RAW stall: issue wr r3, next uses r3 -> in_ready_o=0, stall_cnt_o increments until wb r3 arrives; that cycle issues with wb_int_wd_i=16'hBEEF on int_oper1_o.
REQ-022 Backpressure: out_ready_i=0 for 3 cycles -> outputs unchanged, in_ready_o=0, then drain.
REQ-023 Flush: held instruction writes v2, flush_i=1 -> out_valid_o=0 next cycle, v2 not busy, instruction reading v2 issues immediately.
REQ-024 imm_i=8'h5A -> vec_imm_o=64'h5A5A5A5A5A5A5A5A.
REQ-025 Reset asserted while stalled -> all outputs 0 immediately, scoreboard empty after release.
